halt_detector: RTL

// - Writeback-stage retire monitor for the pipelined CPU; feeds the simulation cycle/finish monitor.
// - Detects a retired HALT and waits a fixed number of cycles so in-flight writes drain.
// - Then raises a sticky is_halt together with a frozen return value, shadowed from the return register.
// - Also counts retired instructions for end-of-run reporting.

---
 rtl/halt_pkg.sv | 18 +
 rtl/halt_drain_timer.sv | 26 ++
 rtl/halt_detector.sv | 126 ++++++++++++
 3 files changed

// File: rtl/halt_pkg.sv
// Shared definitions for the writeback halt monitor and register file.
package halt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 3;

    // Width of a down-counter able to hold 'cycles'; never narrower than 1 bit.
    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/halt_drain_timer.sv
// Loadable down-counter; done is high while the count sits at 1 (last drain cycle).
module halt_drain_timer #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == W'(1));

endmodule

// File: rtl/halt_detector.sv
// Writeback retire monitor: drained HALT detection, return-value shadow, retire counter.
// Optional idle watchdog enabled by defining HALT_WATCHDOG_EN.
module halt_detector
    import halt_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned RET_REG      = 3,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned WDOG_CYCLES  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic              wb_is_halt,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_waddr,
    input  logic [DATA_W-1:0] wb_wdata,
    output logic              is_halt,
    output logic [DATA_W-1:0] ret_val,
    output logic              halt_pending,
    output logic [CNT_W-1:0]  retired_count,
    output logic              wdog_fired
);

    localparam int unsigned TIMER_W = timer_width(DRAIN_CYCLES);

    state_t state;
    logic   halt_in;
    logic   active;
    logic   ret_wr;
    logic   timer_load;
    logic   timer_done;
    logic   wdog_trip;

    assign halt_in    = wb_valid & wb_is_halt;
    assign active     = (state == ST_IDLE) || (state == ST_DRAIN);
    assign ret_wr     = wb_valid && wb_we && (wb_waddr == ADDR_W'(RET_REG)) && (wb_waddr != '0);
    assign timer_load = (state == ST_IDLE) && halt_in && (DRAIN_CYCLES != 0);

    halt_drain_timer #(
        .W (TIMER_W)
    ) u_drain_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_W'(DRAIN_CYCLES)),
        .done     (timer_done)
    );

`ifdef HALT_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] idle_cnt;

    // Only counts in IDLE, so it is implicitly held once draining or halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (wb_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + WDOG_W'(1);
            end
        end
    end

    assign wdog_trip = (state == ST_IDLE) && !wb_valid && (idle_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
    assign wdog_trip  = 1'b0;
    assign wdog_fired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            is_halt       <= 1'b0;
            halt_pending  <= 1'b0;
            ret_val       <= '0;
            retired_count <= '0;
`ifdef HALT_WATCHDOG_EN
            wdog_fired    <= 1'b0;
`endif
        end else begin
            // Status flags follow the state by one edge.
            is_halt      <= (state == ST_HALTED);
            halt_pending <= (state == ST_DRAIN);

            case (state)
                ST_IDLE: begin
                    if (halt_in) begin
                        state <= (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
                    end else if (wdog_trip) begin
                        state <= ST_HALTED;
`ifdef HALT_WATCHDOG_EN
                        wdog_fired <= 1'b1;
`endif
                    end
                end
                ST_DRAIN: begin
                    if (timer_done) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (active) begin
                if (ret_wr) begin
                    ret_val <= wb_wdata;
                end
                if (wb_valid && (retired_count != '1)) begin
                    retired_count <= retired_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
